// File: rtl/cpu_defs.sv
// Shared definitions for the single-cycle MIPS datapath PC stage:
// next-PC operation encodings, PC-stage FSM states and the reset PC default.
package cpu_defs;

  localparam logic [2:0] PC_SEQ  = 3'b000;
  localparam logic [2:0] PC_BEQ  = 3'b001;
  localparam logic [2:0] PC_BNE  = 3'b010;
  localparam logic [2:0] PC_BLTZ = 3'b011;
  localparam logic [2:0] PC_BGEZ = 3'b100;
  localparam logic [2:0] PC_J    = 3'b101;
  localparam logic [2:0] PC_JR   = 3'b110;
  localparam logic [2:0] PC_JAL  = 3'b111;

  localparam logic [31:0] PC_RESET_DFLT = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } pc_state_e;

endpackage

// File: rtl/pc_unit_next_pc_sel.sv
// next_pc_sel: purely combinational next-PC target computation and selection.
// Ports:
//   pc       in  32  current PC
//   pc_src   in  3   next-PC operation (see cpu_defs)
//   zero     in  1   ALU zero flag
//   sign     in  1   ALU sign flag
//   imm_ext  in  32  sign-extended branch offset in words
//   jaddr    in  26  jump index
//   rs_data  in  32  jr target
//   pc_plus4 out 32  pc + 4 (also the jal link value)
//   next_pc  out 32  selected next PC
module next_pc_sel
  import cpu_defs::*;
(
  input  logic [31:0] pc,
  input  logic [2:0]  pc_src,
  input  logic        zero,
  input  logic        sign,
  input  logic [31:0] imm_ext,
  input  logic [25:0] jaddr,
  input  logic [31:0] rs_data,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  logic [31:0] btgt;
  logic [31:0] jtgt;

  assign pc_plus4 = pc + 32'd4;
  assign btgt     = pc_plus4 + (imm_ext << 2);
  assign jtgt     = {pc_plus4[31:28], jaddr, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    unique case (pc_src)
      PC_SEQ:  next_pc = pc_plus4;
      PC_BEQ:  next_pc = zero  ? btgt : pc_plus4;
      PC_BNE:  next_pc = !zero ? btgt : pc_plus4;
      PC_BLTZ: next_pc = sign  ? btgt : pc_plus4;
      PC_BGEZ: next_pc = !sign ? btgt : pc_plus4;
      PC_J,
      PC_JAL:  next_pc = jtgt;
      PC_JR:   next_pc = rs_data;
      default: next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program-counter / next-PC stage of the single-cycle MIPS datapath.
// Owns the PC register, the fetch handshake, halt handling and the fetch
// stall timeout.
// Ports:
//   CLK          in  1   clock, rising edge
//   Reset        in  1   synchronous active-low reset
//   PCSrc        in  3   next-PC operation
//   zero, sign   in  1   ALU flags (used only on commit edges)
//   imm_ext      in  32  branch offset in words
//   jaddr        in  26  jump index
//   rs_data      in  32  jr target
//   halt         in  1   decoded halt instruction
//   imem_ready   in  1   instruction word at pc is valid this cycle
//   pc           out 32  registered PC
//   pc_plus4     out 32  pc + 4, combinational
//   fetch_req    out 1   fetch request (RUN state)
//   branch_taken out 1   last committed instruction redirected the PC
//   halted       out 1   in HALT state
//   fetch_err    out 1   sticky: halted by stall timeout or misaligned jr
module pc_unit
  import cpu_defs::*;
#(
  parameter logic [31:0] PC_RESET  = PC_RESET_DFLT,
  parameter int unsigned MAX_STALL = 16
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [2:0]  PCSrc,
  input  logic        zero,
  input  logic        sign,
  input  logic [31:0] imm_ext,
  input  logic [25:0] jaddr,
  input  logic [31:0] rs_data,
  input  logic        halt,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_req,
  output logic        branch_taken,
  output logic        halted,
  output logic        fetch_err
);

  localparam logic [7:0] STALL_LAST = 8'(MAX_STALL - 1);

  pc_state_e   state, state_nx;
  logic [31:0] pc_nx;
  logic        bt_nx;
  logic        err_nx;
  logic [7:0]  stall_cnt, stall_nx;
  logic [31:0] next_pc;

  next_pc_sel u_sel (
    .pc       (pc),
    .pc_src   (PCSrc),
    .zero     (zero),
    .sign     (sign),
    .imm_ext  (imm_ext),
    .jaddr    (jaddr),
    .rs_data  (rs_data),
    .pc_plus4 (pc_plus4),
    .next_pc  (next_pc)
  );

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    bt_nx    = branch_taken;
    err_nx   = fetch_err;
    stall_nx = stall_cnt;
    unique case (state)
      BOOT: state_nx = RUN;
      RUN: begin
        if (imem_ready) begin
          stall_nx = '0;
          // halt outranks PCSrc; a misaligned jr halts without moving pc
          if (halt) begin
            state_nx = HALT;
          end else if (PCSrc == PC_JR && rs_data[1:0] != 2'b00) begin
            state_nx = HALT;
            err_nx   = 1'b1;
          end else begin
            pc_nx = next_pc;
            bt_nx = (next_pc != pc_plus4);
          end
        end else begin
          stall_nx = stall_cnt + 8'd1;
          if (stall_cnt == STALL_LAST) begin
            state_nx = HALT;
            err_nx   = 1'b1;
          end
        end
      end
      HALT: state_nx = HALT;
      default: state_nx = BOOT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state        <= BOOT;
      pc           <= PC_RESET;
      branch_taken <= 1'b0;
      fetch_err    <= 1'b0;
      stall_cnt    <= '0;
    end else begin
      state        <= state_nx;
      pc           <= pc_nx;
      branch_taken <= bt_nx;
      fetch_err    <= err_nx;
      stall_cnt    <= stall_nx;
    end
  end

  assign fetch_req = (state == RUN);
  assign halted    = (state == HALT);

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;
  import cpu_defs::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  pcsrc;
  logic        zero, sign, halt, ready;
  logic [31:0] imm_ext, rs_data;
  logic [25:0] jaddr;
  logic [31:0] pc, pc_plus4;
  logic        fetch_req, branch_taken, halted, fetch_err;

  always #5 clk = ~clk;

  pc_unit #(.PC_RESET(32'h0000_0000), .MAX_STALL(4)) dut (
    .CLK          (clk),
    .Reset        (rst_n),
    .PCSrc        (pcsrc),
    .zero         (zero),
    .sign         (sign),
    .imm_ext      (imm_ext),
    .jaddr        (jaddr),
    .rs_data      (rs_data),
    .halt         (halt),
    .imem_ready   (ready),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .fetch_req    (fetch_req),
    .branch_taken (branch_taken),
    .halted       (halted),
    .fetch_err    (fetch_err)
  );

  typedef struct {
    logic        rst_n;
    logic [2:0]  src;
    logic        z;
    logic        s;
    logic [31:0] imm;
    logic [25:0] ja;
    logic [31:0] rs;
    logic        hlt;
    logic        rdy;
    logic [31:0] e_pc;
    logic        e_bt;
    logic        e_req;
    logic        e_halted;
    logic        e_err;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] pc;
    logic        bt;
    logic        req;
    logic        hlt;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_app = 0;

  function automatic vec_t mk(logic r, logic [2:0] src, logic z, logic s,
                              logic [31:0] imm, logic [25:0] ja, logic [31:0] rs,
                              logic hlt, logic rdy, logic [31:0] e_pc, logic e_bt,
                              logic e_req, logic e_halted, logic e_err);
    vec_t v;
    v.rst_n = r; v.src = src; v.z = z; v.s = s; v.imm = imm; v.ja = ja;
    v.rs = rs; v.hlt = hlt; v.rdy = rdy; v.e_pc = e_pc; v.e_bt = e_bt;
    v.e_req = e_req; v.e_halted = e_halted; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic apply(vec_t v);
    exp_t e;
    rst_n   = v.rst_n;
    pcsrc   = v.src;
    zero    = v.z;
    sign    = v.s;
    imm_ext = v.imm;
    jaddr   = v.ja;
    rs_data = v.rs;
    halt    = v.hlt;
    ready   = v.rdy;
    e.idx = n_app; e.pc = v.e_pc; e.bt = v.e_bt; e.req = v.e_req;
    e.hlt = v.e_halted; e.err = v.e_err;
    sb.push_back(e);
    n_app++;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("pc",           e.idx, pc,                   e.pc);
    chk("pc_plus4",     e.idx, pc_plus4,             e.pc + 32'd4);
    chk("branch_taken", e.idx, {31'd0, branch_taken}, {31'd0, e.bt});
    chk("fetch_req",    e.idx, {31'd0, fetch_req},    {31'd0, e.req});
    chk("halted",       e.idx, {31'd0, halted},       {31'd0, e.hlt});
    chk("fetch_err",    e.idx, {31'd0, fetch_err},    {31'd0, e.err});
  endtask

  // shorthand for "no redirect operands"
  task automatic stepv(logic r, logic [2:0] src, logic rdy, logic [31:0] rs,
                       logic [31:0] e_pc, logic e_bt, logic e_req, logic e_h, logic e_e);
    apply(mk(r, src, 1'b0, 1'b0, 32'd0, 26'd0, rs, 1'b0, rdy, e_pc, e_bt, e_req, e_h, e_e));
  endtask

  initial begin
    rst_n = 1'b0; pcsrc = PC_SEQ; zero = 0; sign = 0; imm_ext = '0;
    jaddr = '0; rs_data = '0; halt = 0; ready = 0;

    //          rst src      z  s  imm           jaddr        rs            hlt rdy  pc            bt req hlt err
    vecs.push_back(mk(0, PC_SEQ,  0, 0, 32'd0,        26'd0,       32'd0,        0, 1, 32'h0,        0, 0, 0, 0));
    vecs.push_back(mk(1, PC_SEQ,  0, 0, 32'd0,        26'd0,       32'd0,        0, 1, 32'h0,        0, 1, 0, 0));
    vecs.push_back(mk(1, PC_SEQ,  0, 0, 32'd0,        26'd0,       32'd0,        0, 1, 32'h4,        0, 1, 0, 0));
    vecs.push_back(mk(1, PC_SEQ,  0, 0, 32'd0,        26'd0,       32'd0,        0, 1, 32'h8,        0, 1, 0, 0));
    vecs.push_back(mk(1, PC_SEQ,  0, 0, 32'd0,        26'd0,       32'd0,        0, 1, 32'hC,        0, 1, 0, 0));
    vecs.push_back(mk(1, PC_JR,   0, 0, 32'd0,        26'd0,       32'h10,       0, 1, 32'h10,       0, 1, 0, 0));
    vecs.push_back(mk(1, PC_BEQ,  1, 0, 32'hFFFF_FFFC, 26'd0,      32'd0,        0, 1, 32'h04,       1, 1, 0, 0));
    vecs.push_back(mk(1, PC_JR,   0, 0, 32'd0,        26'd0,       32'h10,       0, 1, 32'h10,       1, 1, 0, 0));
    vecs.push_back(mk(1, PC_BEQ,  0, 0, 32'hFFFF_FFFC, 26'd0,      32'd0,        0, 1, 32'h14,       0, 1, 0, 0));
    vecs.push_back(mk(1, PC_BNE,  1, 0, 32'd2,        26'd0,       32'd0,        0, 1, 32'h18,       0, 1, 0, 0));
    vecs.push_back(mk(1, PC_BNE,  0, 0, 32'd2,        26'd0,       32'd0,        0, 1, 32'h24,       1, 1, 0, 0));
    vecs.push_back(mk(1, PC_BLTZ, 0, 1, 32'd1,        26'd0,       32'd0,        0, 1, 32'h2C,       1, 1, 0, 0));
    vecs.push_back(mk(1, PC_BGEZ, 0, 1, 32'd1,        26'd0,       32'd0,        0, 1, 32'h30,       0, 1, 0, 0));
    vecs.push_back(mk(1, PC_BGEZ, 0, 0, 32'd0,        26'd0,       32'd0,        0, 1, 32'h34,       0, 1, 0, 0));
    vecs.push_back(mk(1, PC_JR,   0, 0, 32'd0,        26'd0,       32'h3000_0000, 0, 1, 32'h3000_0000, 1, 1, 0, 0));
    vecs.push_back(mk(1, PC_J,    0, 0, 32'd0,        26'h000_0040, 32'd0,       0, 1, 32'h3000_0100, 1, 1, 0, 0));
    vecs.push_back(mk(1, PC_JAL,  0, 0, 32'd0,        26'h000_0080, 32'd0,       0, 1, 32'h3000_0200, 1, 1, 0, 0));
    vecs.push_back(mk(1, PC_SEQ,  1, 1, 32'd0,        26'd0,       32'd0,        0, 0, 32'h3000_0200, 1, 1, 0, 0));
    vecs.push_back(mk(1, PC_SEQ,  0, 1, 32'd0,        26'd0,       32'd0,        0, 0, 32'h3000_0200, 1, 1, 0, 0));
    vecs.push_back(mk(1, PC_SEQ,  0, 0, 32'd0,        26'd0,       32'd0,        0, 1, 32'h3000_0204, 0, 1, 0, 0));
    vecs.push_back(mk(1, PC_JR,   0, 0, 32'd0,        26'd0,       32'h0000_0042, 0, 1, 32'h3000_0204, 0, 0, 1, 1));
    vecs.push_back(mk(1, PC_SEQ,  0, 0, 32'd0,        26'd0,       32'd0,        0, 1, 32'h3000_0204, 0, 0, 1, 1));
    vecs.push_back(mk(0, PC_SEQ,  0, 0, 32'd0,        26'd0,       32'd0,        0, 1, 32'h0,        0, 0, 0, 0));
    vecs.push_back(mk(1, PC_SEQ,  0, 0, 32'd0,        26'd0,       32'd0,        0, 1, 32'h0,        0, 1, 0, 0));
    vecs.push_back(mk(1, PC_JR,   0, 0, 32'd0,        26'd0,       32'h20,       0, 1, 32'h20,       1, 1, 0, 0));
    vecs.push_back(mk(1, PC_J,    0, 0, 32'd0,        26'h100,     32'd0,        1, 1, 32'h20,       1, 0, 1, 0));
    vecs.push_back(mk(0, PC_SEQ,  0, 0, 32'd0,        26'd0,       32'd0,        0, 1, 32'h0,        0, 0, 0, 0));
    vecs.push_back(mk(1, PC_SEQ,  0, 0, 32'd0,        26'd0,       32'd0,        0, 1, 32'h0,        0, 1, 0, 0));
    vecs.push_back(mk(1, PC_JR,   0, 0, 32'd0,        26'd0,       32'hFFFF_FFFC, 0, 1, 32'hFFFF_FFFC, 1, 1, 0, 0));
    vecs.push_back(mk(1, PC_SEQ,  0, 0, 32'd0,        26'd0,       32'd0,        0, 1, 32'h0,        0, 1, 0, 0));

    foreach (vecs[i]) apply(vecs[i]);

    // halt while not ready is ignored; timeout lands on the 4th stall edge
    apply(mk(1, PC_J, 0, 0, 32'd0, 26'h10, 32'd0, 1, 0, 32'h0, 0, 1, 0, 0));
    stepv(1, PC_SEQ, 0, 32'd0, 32'h0, 0, 1, 0, 0);
    stepv(1, PC_SEQ, 0, 32'd0, 32'h0, 0, 1, 0, 0);
    stepv(1, PC_SEQ, 0, 32'd0, 32'h0, 0, 0, 1, 1);

    // reset in the middle of a stall must clear the stall count
    stepv(0, PC_SEQ, 0, 32'd0, 32'h0, 0, 0, 0, 0);
    stepv(1, PC_SEQ, 0, 32'd0, 32'h0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) stepv(1, PC_SEQ, 0, 32'd0, 32'h0, 0, 1, 0, 0);
    stepv(0, PC_SEQ, 0, 32'd0, 32'h0, 0, 0, 0, 0);
    stepv(1, PC_SEQ, 0, 32'd0, 32'h0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) stepv(1, PC_SEQ, 0, 32'd0, 32'h0, 0, 1, 0, 0);
    stepv(1, PC_SEQ, 1, 32'd0, 32'h4, 0, 1, 0, 0);
    stepv(1, PC_SEQ, 1, 32'd0, 32'h8, 0, 1, 0, 0);

    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Program-counter / next-PC stage directly downstream of the ALU in the single-cycle MIPS datapath.
- Consumes the ALU `zero`/`sign` flags plus decoded control to select the next PC: sequential, conditional branch, jump, jump-register or jump-and-link.
- Owns the PC register and the fetch handshake to instruction memory.
- Handles halt, instruction-fetch stall and stall-timeout.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset.
- MAX_STALL, 16, consecutive cycles `fetch_req` may wait for `imem_ready` before the fetch-error halt; legal range 1..255.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-low reset; sampled on the CLK rising edge.
- PCSrc  in  3  next-PC op: 000 seq, 001 beq, 010 bne, 011 bltz, 100 bgez, 101 j, 110 jr, 111 jal.
- zero  in  1  ALU zero flag for the current instruction.
- sign  in  1  ALU sign flag (result[31]) for the current instruction.
- imm_ext  in  32  sign-extended 16-bit branch offset, in words.
- jaddr  in  26  instr[25:0] jump index.
- rs_data  in  32  register rs value, used by jr.
- halt  in  1  decoded halt instruction.
- imem_ready  in  1  instruction memory has the word at `pc` valid this cycle.
- pc  out  32  current PC (registered).
- pc_plus4  out  32  pc+4 (combinational); also the jal link value.
- fetch_req  out  1  request fetch of `pc` (registered state decode).
- branch_taken  out  1  registered: last committed instruction redirected the PC.
- halted  out  1  block in HALT state.
- fetch_err  out  1  sticky: halt caused by stall timeout or misaligned target.

Behaviour:
- Reset (Reset==0 at the edge, any state, including mid-stall):
  - pc=PC_RESET, state=BOOT, stall_cnt=0.
  - fetch_req=0, branch_taken=0, halted=0, fetch_err=0.
- States:
  - BOOT: unconditionally goes to RUN on the next edge; fetch_req=0.
  - RUN: fetch_req=1.
  - HALT: halted=1, fetch_req=0, pc frozen; left only by reset.
- Commit: an instruction commits on an edge in RUN with imem_ready=1. On commit:
  - pc <= next_pc.
  - branch_taken <= (next_pc != pc_plus4).
  - stall_cnt <= 0.
- Stall: in RUN with imem_ready=0:
  - pc and branch_taken hold; stall_cnt increments.
  - If stall_cnt==MAX_STALL-1 on that edge: go to HALT with fetch_err=1.
- Halt instruction: halt=1 on a commit edge goes to HALT; pc is NOT updated and keeps the halt instruction's address. halt has priority over PCSrc. halt while imem_ready=0 is ignored, since instruction and control are not yet valid.
- next_pc selection (all arithmetic mod 2^32, wrap silently):
  - btgt = pc_plus4 + (imm_ext << 2).
  - jtgt = {pc_plus4[31:28], jaddr, 2'b00}.
  - 000 → pc_plus4.
  - 001 → zero ? btgt : pc_plus4.
  - 010 → !zero ? btgt : pc_plus4.
  - 011 → sign ? btgt : pc_plus4.
  - 100 → !sign ? btgt : pc_plus4.
  - 101, 111 → jtgt.
  - 110 → rs_data.
- jr misalignment: if PCSrc==110 and rs_data[1:0]!=0 on a commit edge, go to HALT with fetch_err=1; pc is not updated.
- Flags: zero/sign are used only on commit edges; during a stall their values are don't-care.
- Overflow of `pc` from 32'hFFFF_FFFC with seq wraps to 0; not an error.
- All outputs except pc_plus4 are registered; next-PC latency is one cycle from commit.

Decomposition:
- Shared package `cpu_defs`:
  - PCSrc encodings as named localparams (PC_SEQ, PC_BEQ, PC_BNE, PC_BLTZ, PC_BGEZ, PC_J, PC_JR, PC_JAL).
  - State encodings: BOOT=2'b00, RUN=2'b01, HALT=2'b10.
  - PC_RESET default.
- One natural sub-module, `next_pc_sel`: purely combinational target computation and selection. The parent holds the FSM, stall counter and registers.

Test Plan:
- Reset, then imem_ready=1, PCSrc=000 for 3 cycles → fetch_req=0 in BOOT; then pc 0→4→8→C; branch_taken=0.
- At pc=32'h10: beq with zero=1, imem_ext=32'hFFFF_FFFC, ready=1 → pc=32'h04, branch_taken=1. Same case with zero=0 → pc=32'h14, branch_taken=0.
- At pc=32'h3000_0000: j with jaddr=26'h000_0040 → pc=32'h3000_0100. jr with rs_data=32'h0000_0042 → halted=1, fetch_err=1, pc unchanged.
- MAX_STALL=4: imem_ready held 0 → pc held; HALT with fetch_err=1 exactly on the 4th stall edge. Repeat with ready asserted on stall cycle 3 → commit, no error.
- halt=1 with ready=1 at pc=32'h20 → halted=1, pc stays 32'h20, fetch_req=0. Reset low mid-HALT → pc=PC_RESET, halted=0, fetch_err=0.
- pc=32'hFFFF_FFFC, seq → pc=0, no error. Reset asserted during a stall → stall_cnt cleared; no timeout after resuming.
